lc3_control_fsm: RTL and testbench
==================================

Name: lc3_control_fsm

Overview:
Moore control unit that sequences the LC-3 datapath through fetch, decode and execute, driving every load, gate and mux-select input of the datapath. It counts fixed memory wait states, supports a PAUSE instruction with a Continue handshake, and holds the machine idle until Run. It sits beside the datapath in the top level. Opcode and IR bits come from the datapath IR, and BEN comes from its BEN register.

Parameters:
MEM_WAIT, 2, number of cycles each memory read/write state is held (1..7); counter width is 3 bits.

Ports:
Clk  in  1  system clock, rising edge
Reset_al  in  1  asynchronous, active-low reset
Run  in  1  start from HALTED (level, sampled each cycle)
Continue  in  1  release from PAUSE (level)
Opcode  in  4  IR[15:12]
IR_5  in  1  immediate-mode bit for ADD/AND
IR_11  in  1  JSR vs JSRR select
BEN  in  1  registered branch enable from datapath
LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out  1 each  register loads
GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers, at most one high per cycle
PCMUX  out  2  00 BUS, 01 adder, 10 PC+1
ADDR2MUX  out  2  00 SEXT11, 01 SEXT9, 10 SEXT6, 11 zero
ADDR1MUX  out  1  0 SR1, 1 PC
ALUK  out  2  00 ADD, 01 AND, 10 NOT, 11 pass SR1
SR1MUX  out  1  0 IR[11:9], 1 IR[8:6]
DRMUX  out  1  0 IR[11:9], 1 R7
MIO_EN  out  1  1 = MDR loads from memory
Mem_OE, Mem_WE  out  1 each  memory read/write strobes, active high
State  out  5  current state code for debug/LED

Behaviour:
- Reset: Reset_al low asynchronously forces HALTED and clears the wait counter. All outputs default to 0 in every state unless listed below, including during reset.
- Outputs are a pure function of state (Moore). No combinational path from inputs to outputs.
- HALTED: go to S18 when Run=1; otherwise stay.
- S18: GatePC, LD_MAR, PCMUX=10, LD_PC. Next state S33.
- S33: Mem_OE, MIO_EN, LD_MDR. Held exactly MEM_WAIT cycles, then S35.
- S35: GateMDR, LD_IR. Next state S32.
- S32: LD_BEN. Decode Opcode:
  - 0001 -> S01
  - 0101 -> S05
  - 1001 -> S09
  - 0000 -> S00
  - 1100 -> S12
  - 0100 -> S04
  - 0110 -> S06
  - 0111 -> S07
  - 1101 -> PAUSE1
  - any other -> S18 (treated as NOP)
- S01/S05/S09: SR1MUX=1, DRMUX=0, ALUK=00/01/10, GateALU, LD_REG, LD_CC. Next state S18. IR_5 is decoded by the datapath SR2 mux; it is not a controller output.
- S00: next state S22 if BEN=1, else S18. BEN is valid here because it was loaded in S32.
- S22: ADDR1MUX=1, ADDR2MUX=01, PCMUX=01, LD_PC. Next state S18.
- S12: SR1MUX=1, ALUK=11, GateALU, PCMUX=00, LD_PC. Next state S18.
- S04: GatePC, DRMUX=1, LD_REG. Next state S21 if IR_11=1, else S20.
- S21: ADDR1MUX=1, ADDR2MUX=00, PCMUX=01, LD_PC. Next state S18.
- S20: SR1MUX=1, ADDR1MUX=0, ADDR2MUX=11, PCMUX=01, LD_PC. Next state S18.
- S06 (LDR address): SR1MUX=1, ADDR1MUX=0, ADDR2MUX=10, GateMARMUX, LD_MAR. Next state S25.
- S25: Mem_OE, MIO_EN, LD_MDR. Held MEM_WAIT cycles, then S27.
- S27: GateMDR, DRMUX=0, LD_REG, LD_CC. Next state S18.
- S07 (STR address): same address outputs as S06. Next state S23.
- S23: SR1MUX=0, ALUK=11, GateALU, MIO_EN=0, LD_MDR. Next state S16.
- S16: Mem_WE. Held MEM_WAIT cycles, then S18.
- PAUSE1: LD_LED. Stay while Continue=0; go to PAUSE2 when Continue=1.
- PAUSE2: stay while Continue=1; go to S18 when Continue=0. This gives one instruction per press.
- Wait counter: loads MEM_WAIT-1 on entry to a memory state and decrements each cycle; the state exits on the cycle the count is 0. With MEM_WAIT=1 each memory state lasts exactly 1 cycle.
- Run is ignored outside HALTED. Only reset returns the FSM to HALTED.
- Reset asserted mid-instruction abandons the instruction immediately. Any Mem_WE pulse is cut short.
- Unused state encodings go to HALTED on the next clock.

Test Plan:
- Reset low with Run=1 -> State=HALTED and all outputs 0. Release reset -> S18 on the first edge; LD_MAR=1, GatePC=1, PCMUX=10.
- MEM_WAIT=2, Opcode=0001 -> sequence S18, S33, S33, S35, S32, S01, S18 (7 cycles). In S01: LD_REG=1, LD_CC=1, ALUK=00.
- Opcode=0000: BEN=0 -> S32, S00, S18. BEN=1 -> S32, S00, S22, S18 with PCMUX=01 and ADDR2MUX=01 in S22.
- Opcode=0111, MEM_WAIT=3 -> Mem_WE high for exactly 3 consecutive cycles in S16. LD_MDR=1 with MIO_EN=0 in S23.
- Opcode=1101 with Continue held 0 for 5 cycles -> stays in PAUSE1 with LD_LED=1. Continue=1 -> PAUSE2. Continue=0 -> S18.
- Opcode=1111 -> S32 then S18 with no LD_REG/LD_PC. Reset pulsed low during S16 -> HALTED asynchronously and Mem_WE=0 at once.

Source files
------------

// File: rtl/lc3_control_fsm.sv
// lc3_control_fsm: Moore sequencer driving the LC-3 datapath through fetch, decode and execute,
// with fixed memory wait states, a PAUSE/Continue handshake and an idle HALTED state.
module lc3_control_fsm #(
    parameter int MEM_WAIT = 2
) (
    input  logic       Clk,
    input  logic       Reset_al,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic [1:0] ADDR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ALUK,
    output logic       SR1MUX,
    output logic       DRMUX,
    output logic       MIO_EN,
    output logic       Mem_OE,
    output logic       Mem_WE,
    output logic [4:0] State
);
    // HALTED is code 0 so State reads 0 while reset is held; other codes follow the LC-3 state numbers where they fit
    typedef enum logic [4:0] {
        HALTED = 5'd0,  S01 = 5'd1,  S32 = 5'd2,  S33 = 5'd3,  S04 = 5'd4,  S05 = 5'd5,
        S06 = 5'd6,  S07 = 5'd7,  S35 = 5'd8,  S09 = 5'd9,  PAUSE1 = 5'd10, PAUSE2 = 5'd11,
        S12 = 5'd12, S16 = 5'd16, S18 = 5'd18, S20 = 5'd20, S21 = 5'd21, S22 = 5'd22,
        S23 = 5'd23, S00 = 5'd24, S25 = 5'd25, S27 = 5'd27
    } state_t;

    localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT - 1);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       mem_done;
    logic [2:0] cnt_next;
    logic       ir5_unused;

    assign ir5_unused = IR_5;
    assign mem_done   = cnt_q == 3'd0;
    assign cnt_next   = mem_done ? WAIT_INIT : cnt_q - 3'd1;
    assign State      = state_q;

    always_ff @(posedge Clk or negedge Reset_al)
        if (!Reset_al) begin
            state_q <= HALTED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end

    always_comb begin
        state_d    = HALTED;
        cnt_d      = WAIT_INIT;
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        LD_LED     = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = 2'b00;
        ADDR2MUX   = 2'b00;
        ADDR1MUX   = 1'b0;
        ALUK       = 2'b00;
        SR1MUX     = 1'b0;
        DRMUX      = 1'b0;
        MIO_EN     = 1'b0;
        Mem_OE     = 1'b0;
        Mem_WE     = 1'b0;
        case (state_q)
            HALTED: state_d = Run ? S18 : HALTED;
            S18: begin
                GatePC  = 1'b1;
                LD_MAR  = 1'b1;
                PCMUX   = 2'b10;
                LD_PC   = 1'b1;
                state_d = S33;
            end
            S33, S25: begin
                Mem_OE  = 1'b1;
                MIO_EN  = 1'b1;
                LD_MDR  = 1'b1;
                cnt_d   = cnt_next;
                state_d = !mem_done ? state_q : (state_q == S33) ? S35 : S27;
            end
            S35: begin
                GateMDR = 1'b1;
                LD_IR   = 1'b1;
                state_d = S32;
            end
            S32: begin
                LD_BEN = 1'b1;
                case (Opcode)
                    4'b0001: state_d = S01;
                    4'b0101: state_d = S05;
                    4'b1001: state_d = S09;
                    4'b0000: state_d = S00;
                    4'b1100: state_d = S12;
                    4'b0100: state_d = S04;
                    4'b0110: state_d = S06;
                    4'b0111: state_d = S07;
                    4'b1101: state_d = PAUSE1;
                    default: state_d = S18;
                endcase
            end
            S01, S05, S09: begin
                SR1MUX  = 1'b1;
                ALUK    = (state_q == S05) ? 2'b01 : (state_q == S09) ? 2'b10 : 2'b00;
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                state_d = S18;
            end
            S00: state_d = BEN ? S22 : S18;
            S22, S21: begin
                ADDR1MUX = 1'b1;
                ADDR2MUX = (state_q == S22) ? 2'b01 : 2'b00;
                PCMUX    = 2'b01;
                LD_PC    = 1'b1;
                state_d  = S18;
            end
            S12: begin
                SR1MUX  = 1'b1;
                ALUK    = 2'b11;
                GateALU = 1'b1;
                LD_PC   = 1'b1;
                state_d = S18;
            end
            S04: begin
                GatePC  = 1'b1;
                DRMUX   = 1'b1;
                LD_REG  = 1'b1;
                state_d = IR_11 ? S21 : S20;
            end
            S20: begin
                SR1MUX   = 1'b1;
                ADDR2MUX = 2'b11;
                PCMUX    = 2'b01;
                LD_PC    = 1'b1;
                state_d  = S18;
            end
            S06, S07: begin
                SR1MUX     = 1'b1;
                ADDR2MUX   = 2'b10;
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
                state_d    = (state_q == S06) ? S25 : S23;
            end
            S27: begin
                GateMDR = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                state_d = S18;
            end
            S23: begin
                ALUK    = 2'b11;
                GateALU = 1'b1;
                LD_MDR  = 1'b1;
                state_d = S16;
            end
            S16: begin
                Mem_WE  = 1'b1;
                cnt_d   = cnt_next;
                state_d = mem_done ? S18 : S16;
            end
            PAUSE1: begin
                LD_LED  = 1'b1;
                state_d = Continue ? PAUSE2 : PAUSE1;
            end
            PAUSE2: state_d = Continue ? PAUSE2 : S18;
            default: state_d = HALTED;
        endcase
    end
endmodule

// File: tb/tb_lc3_control_fsm.sv
// tb_lc3_control_fsm: two instances (MEM_WAIT 2 and 3) run randomized instruction streams
// against per-instruction expected state traces built from the opcode rules.
module tb_lc3_control_fsm;
    localparam int N = 2;
    localparam logic [4:0] HALT = 5'd0, S00 = 5'd24, S01 = 5'd1, S04 = 5'd4, S05 = 5'd5, S06 = 5'd6,
                           S07 = 5'd7, S09 = 5'd9, S12 = 5'd12, S16 = 5'd16, S18 = 5'd18, S20 = 5'd20,
                           S21 = 5'd21, S22 = 5'd22, S23 = 5'd23, S25 = 5'd25, S27 = 5'd27, S32 = 5'd2,
                           S33 = 5'd3, S35 = 5'd8, P1 = 5'd10, P2 = 5'd11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n[N], run[N], cont[N], ir5[N], ir11[N], ben[N];
    logic [3:0]  opc[N];
    logic [23:0] outs[N];
    logic [4:0]  st[N];
    int checks = 0, fails = 0;

    for (genvar g = 0; g < N; g++) begin : g_dut
        logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic gate_pc, gate_mdr, gate_alu, gate_marmux, addr1mux, sr1mux, drmux, mio_en, mem_oe, mem_we;
        logic [1:0] pcmux, addr2mux, aluk;
        lc3_control_fsm #(.MEM_WAIT(2 + g)) dut (
            .Clk(clk), .Reset_al(rst_n[g]), .Run(run[g]), .Continue(cont[g]), .Opcode(opc[g]),
            .IR_5(ir5[g]), .IR_11(ir11[g]), .BEN(ben[g]),
            .LD_MAR(ld_mar), .LD_MDR(ld_mdr), .LD_IR(ld_ir), .LD_BEN(ld_ben), .LD_CC(ld_cc),
            .LD_REG(ld_reg), .LD_PC(ld_pc), .LD_LED(ld_led), .GatePC(gate_pc), .GateMDR(gate_mdr),
            .GateALU(gate_alu), .GateMARMUX(gate_marmux), .PCMUX(pcmux), .ADDR2MUX(addr2mux),
            .ADDR1MUX(addr1mux), .ALUK(aluk), .SR1MUX(sr1mux), .DRMUX(drmux), .MIO_EN(mio_en),
            .Mem_OE(mem_oe), .Mem_WE(mem_we), .State(st[g])
        );
        assign outs[g] = {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led,
                          gate_pc, gate_mdr, gate_alu, gate_marmux, pcmux, addr2mux, addr1mux,
                          aluk, sr1mux, drmux, mio_en, mem_oe, mem_we};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ld = MAR MDR IR BEN CC REG PC LED, gt = PC MDR ALU MARMUX
    function automatic logic [23:0] ctl(input logic [7:0] ld, input logic [3:0] gt, input logic [1:0] pcm,
                                        input logic [1:0] a2, input logic a1, input logic [1:0] alu,
                                        input logic sr1, input logic dr, input logic mio, input logic oe,
                                        input logic we);
        return {ld, gt, pcm, a2, a1, alu, sr1, dr, mio, oe, we};
    endfunction

    function automatic logic [23:0] ctl_of(input logic [4:0] s);
        case (s)
            S18:      return ctl(8'b1000_0010, 4'b1000, 2'b10, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0);
            S33, S25: return ctl(8'b0100_0000, 4'b0000, 2'b00, 2'b00, 0, 2'b00, 0, 0, 1, 1, 0);
            S35:      return ctl(8'b0010_0000, 4'b0100, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0);
            S32:      return ctl(8'b0001_0000, 4'b0000, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0);
            S01:      return ctl(8'b0000_1100, 4'b0010, 2'b00, 2'b00, 0, 2'b00, 1, 0, 0, 0, 0);
            S05:      return ctl(8'b0000_1100, 4'b0010, 2'b00, 2'b00, 0, 2'b01, 1, 0, 0, 0, 0);
            S09:      return ctl(8'b0000_1100, 4'b0010, 2'b00, 2'b00, 0, 2'b10, 1, 0, 0, 0, 0);
            S22:      return ctl(8'b0000_0010, 4'b0000, 2'b01, 2'b01, 1, 2'b00, 0, 0, 0, 0, 0);
            S12:      return ctl(8'b0000_0010, 4'b0010, 2'b00, 2'b00, 0, 2'b11, 1, 0, 0, 0, 0);
            S04:      return ctl(8'b0000_0100, 4'b1000, 2'b00, 2'b00, 0, 2'b00, 0, 1, 0, 0, 0);
            S21:      return ctl(8'b0000_0010, 4'b0000, 2'b01, 2'b00, 1, 2'b00, 0, 0, 0, 0, 0);
            S20:      return ctl(8'b0000_0010, 4'b0000, 2'b01, 2'b11, 0, 2'b00, 1, 0, 0, 0, 0);
            S06, S07: return ctl(8'b1000_0000, 4'b0001, 2'b00, 2'b10, 0, 2'b00, 1, 0, 0, 0, 0);
            S27:      return ctl(8'b0000_1100, 4'b0100, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0);
            S23:      return ctl(8'b0100_0000, 4'b0010, 2'b00, 2'b00, 0, 2'b11, 0, 0, 0, 0, 0);
            S16:      return ctl(8'b0000_0000, 4'b0000, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0, 1);
            P1:       return ctl(8'b0000_0001, 4'b0000, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0);
            default:  return '0;
        endcase
    endfunction

    // Builds the expected per-cycle trace {state, Continue to drive} of one instruction and checks it;
    // cut >= 0 pulls reset mid-cycle at that trace position.
    task automatic run_insn(input int i, input logic [3:0] op, input logic b, input logic j,
                            input int p, input int r, input int cut);
        logic [5:0] q[$];
        int mw = 2 + i;
        q.push_back({S18, 1'($urandom)});
        for (int k = 0; k < mw; k++) q.push_back({S33, 1'($urandom)});
        q.push_back({S35, 1'($urandom)});
        q.push_back({S32, 1'($urandom)});
        case (op)
            4'b0001: q.push_back({S01, 1'($urandom)});
            4'b0101: q.push_back({S05, 1'($urandom)});
            4'b1001: q.push_back({S09, 1'($urandom)});
            4'b1100: q.push_back({S12, 1'($urandom)});
            4'b0000: begin
                q.push_back({S00, 1'($urandom)});
                if (b) q.push_back({S22, 1'($urandom)});
            end
            4'b0100: begin
                q.push_back({S04, 1'($urandom)});
                q.push_back({j ? S21 : S20, 1'($urandom)});
            end
            4'b0110: begin
                q.push_back({S06, 1'($urandom)});
                for (int k = 0; k < mw; k++) q.push_back({S25, 1'($urandom)});
                q.push_back({S27, 1'($urandom)});
            end
            4'b0111: begin
                q.push_back({S07, 1'($urandom)});
                q.push_back({S23, 1'($urandom)});
                for (int k = 0; k < mw; k++) q.push_back({S16, 1'($urandom)});
            end
            4'b1101: begin
                for (int k = 0; k < p; k++) q.push_back({P1, 1'b0});
                q.push_back({P1, 1'b1});
                for (int k = 1; k < r; k++) q.push_back({P2, 1'b1});
                q.push_back({P2, 1'b0});
            end
            default: ;
        endcase
        foreach (q[k]) begin
            @(posedge clk);
            #1;
            check($sformatf("u%0d op%b k%0d state", i, op, k), 32'(st[i]), 32'(q[k][5:1]));
            check($sformatf("u%0d op%b k%0d ctl", i, op, k), 32'(outs[i]), 32'(ctl_of(q[k][5:1])));
            if (k == cut) begin
                #2 rst_n[i] = 1'b0;
                run[i] = 1'b0;
                #1;
                check($sformatf("u%0d async_rst state", i), 32'(st[i]), 32'(HALT));
                check($sformatf("u%0d async_rst ctl", i), 32'(outs[i]), 32'd0);
                return;
            end
            if (k == 0) begin
                opc[i] = op;
                ben[i] = b;
                ir11[i] = j;
            end
            cont[i] = q[k][0];
            run[i] = 1'($urandom);
            ir5[i] = 1'($urandom);
        end
    endtask

    task automatic drive(input int i);
        rst_n[i] = 1'b0;
        run[i] = 1'b1;
        cont[i] = 1'b0;
        ir5[i] = 1'b0;
        ir11[i] = 1'b0;
        ben[i] = 1'b0;
        opc[i] = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        check($sformatf("u%0d reset state", i), 32'(st[i]), 32'(HALT));
        check($sformatf("u%0d reset ctl", i), 32'(outs[i]), 32'd0);
        @(negedge clk) rst_n[i] = 1'b1;
        run_insn(i, 4'b0001, 1'b0, 1'b0, 0, 1, -1);
        run_insn(i, 4'b0000, 1'b0, 1'b0, 0, 1, -1);
        run_insn(i, 4'b0000, 1'b1, 1'b0, 0, 1, -1);
        run_insn(i, 4'b0111, 1'b0, 1'b0, 0, 1, -1);
        run_insn(i, 4'b1101, 1'b0, 1'b0, 5, 2, -1);
        run_insn(i, 4'b1111, 1'b1, 1'b1, 0, 1, -1);
        run_insn(i, 4'b0101, 1'b0, 1'b0, 0, 1, -1);
        run_insn(i, 4'b1001, 1'b0, 1'b0, 0, 1, -1);
        run_insn(i, 4'b1100, 1'b0, 1'b0, 0, 1, -1);
        run_insn(i, 4'b0100, 1'b0, 1'b1, 0, 1, -1);
        run_insn(i, 4'b0100, 1'b0, 1'b0, 0, 1, -1);
        run_insn(i, 4'b0110, 1'b0, 1'b0, 0, 1, -1);
        repeat (40)
            run_insn(i, 4'($urandom), 1'($urandom), 1'($urandom), 32'($urandom_range(0, 4)),
                     32'($urandom_range(1, 3)), -1);
        run_insn(i, 4'b0111, 1'b0, 1'b0, 0, 1, 2 + i + 6);
        repeat (2) begin
            @(posedge clk);
            #1;
            check($sformatf("u%0d in_reset state", i), 32'(st[i]), 32'(HALT));
        end
        @(negedge clk) rst_n[i] = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check($sformatf("u%0d idle state", i), 32'(st[i]), 32'(HALT));
            check($sformatf("u%0d idle ctl", i), 32'(outs[i]), 32'd0);
        end
        run[i] = 1'b1;
        @(posedge clk);
        #1;
        check($sformatf("u%0d restart state", i), 32'(st[i]), 32'(S18));
    endtask

    initial begin
        fork
            drive(0);
            drive(1);
        join
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
